// File: rtl/sram_like_arbiter.sv
// Two-master sram-like arbiter (m1 data over m0 inst) with grant lock and an in-order source FIFO for response routing.
// Optional build macro SRAM_ARB_RR_EN switches idle arbitration to round-robin.
module sram_like_arbiter #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             m0_req,
  input  logic             m0_wr,
  input  logic [1:0]       m0_size,
  input  logic [3:0]       m0_wstrb,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m0_wdata,
  output logic             m0_addr_ok,
  output logic             m0_data_ok,
  output logic [31:0]      m0_rdata,
  input  logic             m1_req,
  input  logic             m1_wr,
  input  logic [1:0]       m1_size,
  input  logic [3:0]       m1_wstrb,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m1_wdata,
  output logic             m1_addr_ok,
  output logic             m1_data_ok,
  output logic [31:0]      m1_rdata,
  output logic             s_req,
  output logic             s_wr,
  output logic [1:0]       s_size,
  output logic [3:0]       s_wstrb,
  output logic [31:0]      s_addr,
  output logic [31:0]      s_wdata,
  input  logic             s_addr_ok,
  input  logic             s_data_ok,
  input  logic [31:0]      s_rdata,
  output logic [PTR_W:0]   outstanding,
  output logic             err_spurious
);

  typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

  state_t             r_state;
  logic [DEPTH-1:0]   r_src;
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [PTR_W:0]     r_count;
  logic               r_err;
`ifdef SRAM_ARB_RR_EN
  logic               r_last;
`endif

  logic w_full;
  logic w_gnt_vld;
  logic w_gnt;
  logic w_hs;
  logic w_pop;
  logic w_head;

  // A lock whose master has dropped req falls through to normal idle arbitration.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = 1'b0;
    if (r_state == LOCK0 && m0_req) begin
      w_gnt_vld = 1'b1;
      w_gnt     = 1'b0;
    end else if (r_state == LOCK1 && m1_req) begin
      w_gnt_vld = 1'b1;
      w_gnt     = 1'b1;
    end else begin
`ifdef SRAM_ARB_RR_EN
      if (m0_req && m1_req) begin
        w_gnt_vld = 1'b1;
        w_gnt     = ~r_last;
      end else if (m1_req) begin
`else
      if (m1_req) begin
`endif
        w_gnt_vld = 1'b1;
        w_gnt     = 1'b1;
      end else if (m0_req) begin
        w_gnt_vld = 1'b1;
        w_gnt     = 1'b0;
      end
    end
    if (!resetn) begin
      w_gnt_vld = 1'b0;
    end
  end

  assign w_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign s_req   = w_gnt_vld & ~w_full;
  assign s_wr    = w_gnt_vld & (w_gnt ? m1_wr : m0_wr);
  assign s_size  = w_gnt_vld ? (w_gnt ? m1_size  : m0_size)  : 2'b0;
  assign s_wstrb = w_gnt_vld ? (w_gnt ? m1_wstrb : m0_wstrb) : 4'b0;
  assign s_addr  = w_gnt_vld ? (w_gnt ? m1_addr  : m0_addr)  : 32'b0;
  assign s_wdata = w_gnt_vld ? (w_gnt ? m1_wdata : m0_wdata) : 32'b0;

  assign w_hs       = s_req & s_addr_ok;
  assign m0_addr_ok = w_hs & ~w_gnt;
  assign m1_addr_ok = w_hs &  w_gnt;

  assign w_pop      = resetn & s_data_ok & (r_count != '0);
  assign w_head     = r_src[r_rptr];
  assign m0_data_ok = w_pop & ~w_head;
  assign m1_data_ok = w_pop &  w_head;
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;

  assign outstanding  = r_count;
  assign err_spurious = r_err;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_src   <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
`ifdef SRAM_ARB_RR_EN
      r_last  <= 1'b0;
`endif
    end else begin
      if (w_hs) begin
        r_src[r_wptr] <= w_gnt;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_hs, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (s_data_ok && r_count == '0) begin
        r_err <= 1'b1;
      end
      // Stay on the granted master until its request is accepted.
      if (w_gnt_vld && !w_hs) begin
        r_state <= w_gnt ? LOCK1 : LOCK0;
      end else begin
        r_state <= IDLE;
      end
`ifdef SRAM_ARB_RR_EN
      if (w_hs) begin
        r_last <= w_gnt;
      end
`endif
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Self-checking bench for sram_like_arbiter: directed vector table, priority sequence and randomized queue-based model.
module tb_sram_like_arbiter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        m0_req, m0_wr, m1_req, m1_wr;
  logic [1:0]  m0_size, m1_size;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_req, s_wr, s_addr_ok, s_data_ok;
  logic [1:0]  s_size;
  logic [3:0]  s_wstrb;
  logic [31:0] s_addr, s_wdata, s_rdata;
  logic [2:0]  outstanding;
  logic        err_spurious;

  int n_chk = 0;
  int n_err = 0;

  int lockm;
  int q[$];
  bit merr;
  bit mlast;

  always #5 clk = ~clk;

  sram_like_arbiter #(.DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_size(m0_size), .m0_wstrb(m0_wstrb),
    .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_addr_ok(m0_addr_ok),
    .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_size(m1_size), .m1_wstrb(m1_wstrb),
    .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_addr_ok(m1_addr_ok),
    .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_wstrb(s_wstrb),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_addr_ok(s_addr_ok),
    .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .outstanding(outstanding), .err_spurious(err_spurious)
  );

  typedef struct {
    logic        rstn, r0, r1, aok, dok;
    logic [31:0] rdata;
    logic        e_sreq;
    logic [31:0] e_addr;
    logic        e_a0, e_a1, e_d0, e_d1;
    logic [2:0]  e_out;
    logic        e_err;
  } vec_t;

  vec_t tbl[24];

  function automatic vec_t mk(logic rstn, logic r0, logic r1, logic aok, logic dok,
                              logic [31:0] rdata, logic sreq, logic [31:0] addr,
                              logic a0, logic a1, logic d0, logic d1,
                              logic [2:0] out, logic err);
    vec_t v;
    v.rstn = rstn; v.r0 = r0; v.r1 = r1; v.aok = aok; v.dok = dok; v.rdata = rdata;
    v.e_sreq = sreq; v.e_addr = addr; v.e_a0 = a0; v.e_a1 = a1;
    v.e_d0 = d0; v.e_d1 = d1; v.e_out = out; v.e_err = err;
    return v;
  endfunction

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction

  task automatic set_fixed_masters();
    m0_wr = 1'b0; m0_size = 2'd2; m0_wstrb = 4'hf; m0_addr = 32'h100;  m0_wdata = 32'h1111_1111;
    m1_wr = 1'b1; m1_size = 2'd1; m1_wstrb = 4'h3; m1_addr = 32'h1000; m1_wdata = 32'h2222_2222;
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0; m0_req = 1'b0; m1_req = 1'b0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
    @(posedge clk);
    lockm = -1; q.delete(); merr = 1'b0; mlast = 1'b0;
  endtask

  task automatic rand_cycle();
    int g;
    bit full, esreq, hs, pop, spur, ed0, ed1;
    logic [31:0] eaddr, ewdata;
    logic [1:0] esize;
    logic [3:0] ewstrb;
    logic ewr;
    @(negedge clk);
    resetn    = 1'b1;
    m0_req    = ($urandom_range(0, 9) < 6);
    m1_req    = ($urandom_range(0, 9) < 6);
    s_addr_ok = ($urandom_range(0, 9) < 5);
    s_data_ok = ($urandom_range(0, 9) < 4);
    s_rdata   = $urandom;
    m0_addr = $urandom; m0_wdata = $urandom; m0_wr = 1'($urandom); m0_size = 2'($urandom); m0_wstrb = 4'($urandom);
    m1_addr = $urandom; m1_wdata = $urandom; m1_wr = 1'($urandom); m1_size = 2'($urandom); m1_wstrb = 4'($urandom);
    #2;
    g = -1;
    if (lockm == 0 && m0_req) g = 0;
    else if (lockm == 1 && m1_req) g = 1;
    else if (m0_req && m1_req) begin
`ifdef SRAM_ARB_RR_EN
      g = mlast ? 0 : 1;
`else
      g = 1;
`endif
    end
    else if (m1_req) g = 1;
    else if (m0_req) g = 0;
    full  = (q.size() == 4);
    esreq = (g >= 0) && !full;
    hs    = esreq && s_addr_ok;
    pop   = s_data_ok && (q.size() > 0);
    spur  = s_data_ok && (q.size() == 0);
    ed0   = pop && (q[0] == 0);
    ed1   = pop && (q[0] == 1);
    eaddr  = (g == 1) ? m1_addr  : (g == 0) ? m0_addr  : 32'h0;
    ewdata = (g == 1) ? m1_wdata : (g == 0) ? m0_wdata : 32'h0;
    esize  = (g == 1) ? m1_size  : (g == 0) ? m0_size  : 2'h0;
    ewstrb = (g == 1) ? m1_wstrb : (g == 0) ? m0_wstrb : 4'h0;
    ewr    = (g == 1) ? m1_wr    : (g == 0) ? m0_wr    : 1'b0;
    chk("rnd_s_req", 32'(s_req), 32'(esreq));
    chk("rnd_s_addr", s_addr, eaddr);
    chk("rnd_s_wdata", s_wdata, ewdata);
    chk("rnd_s_size", 32'(s_size), 32'(esize));
    chk("rnd_s_wstrb", 32'(s_wstrb), 32'(ewstrb));
    chk("rnd_s_wr", 32'(s_wr), 32'(ewr));
    chk("rnd_m0_addr_ok", 32'(m0_addr_ok), 32'(hs && g == 0));
    chk("rnd_m1_addr_ok", 32'(m1_addr_ok), 32'(hs && g == 1));
    chk("rnd_m0_data_ok", 32'(m0_data_ok), 32'(ed0));
    chk("rnd_m1_data_ok", 32'(m1_data_ok), 32'(ed1));
    chk("rnd_m0_rdata", m0_rdata, s_rdata);
    chk("rnd_m1_rdata", m1_rdata, s_rdata);
    chk("rnd_outstanding", 32'(outstanding), 32'(q.size()));
    chk("rnd_err_spurious", 32'(err_spurious), 32'(merr));
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (hs) q.push_back(g);
    if (spur) merr = 1'b1;
    lockm = (g >= 0 && !hs) ? g : -1;
    if (hs) mlast = (g == 1);
  endtask

  initial begin
    logic [31:0] exp_pri[4];
`ifdef SRAM_ARB_RR_EN
    exp_pri[0] = 32'h1000; exp_pri[1] = 32'h100; exp_pri[2] = 32'h1000; exp_pri[3] = 32'h100;
`else
    exp_pri[0] = 32'h1000; exp_pri[1] = 32'h1000; exp_pri[2] = 32'h1000; exp_pri[3] = 32'h1000;
`endif

    tbl[0]  = mk(0,1,1,1,0,32'h0, 0,32'h0,    0,0,0,0, 3'd0,0);
    tbl[1]  = mk(0,1,1,1,0,32'h0, 0,32'h0,    0,0,0,0, 3'd0,0);
    tbl[2]  = mk(1,1,1,1,0,32'h0, 1,32'h1000, 0,1,0,0, 3'd0,0);
    tbl[3]  = mk(1,1,0,1,0,32'h0, 1,32'h100,  1,0,0,0, 3'd1,0);
    tbl[4]  = mk(1,0,0,0,1,32'hA, 0,32'h0,    0,0,0,1, 3'd2,0);
    tbl[5]  = mk(1,0,0,0,1,32'hB, 0,32'h0,    0,0,1,0, 3'd1,0);
    tbl[6]  = mk(1,0,0,0,0,32'h0, 0,32'h0,    0,0,0,0, 3'd0,0);
    tbl[7]  = mk(1,1,0,0,0,32'h0, 1,32'h100,  0,0,0,0, 3'd0,0);
    tbl[8]  = mk(1,1,1,0,0,32'h0, 1,32'h100,  0,0,0,0, 3'd0,0);
    tbl[9]  = mk(1,1,1,0,0,32'h0, 1,32'h100,  0,0,0,0, 3'd0,0);
    tbl[10] = mk(1,1,1,1,0,32'h0, 1,32'h100,  1,0,0,0, 3'd0,0);
    tbl[11] = mk(1,0,1,1,0,32'h0, 1,32'h1000, 0,1,0,0, 3'd1,0);
    tbl[12] = mk(1,1,0,1,0,32'h0, 1,32'h100,  1,0,0,0, 3'd2,0);
    tbl[13] = mk(1,0,1,1,0,32'h0, 1,32'h1000, 0,1,0,0, 3'd3,0);
    tbl[14] = mk(1,1,0,1,0,32'h0, 0,32'h100,  0,0,0,0, 3'd4,0);
    tbl[15] = mk(1,1,0,1,1,32'hA, 0,32'h100,  0,0,1,0, 3'd4,0);
    tbl[16] = mk(1,1,0,1,1,32'hB, 1,32'h100,  1,0,0,1, 3'd3,0);
    tbl[17] = mk(1,0,0,0,1,32'hC, 0,32'h0,    0,0,1,0, 3'd3,0);
    tbl[18] = mk(1,0,0,0,1,32'hD, 0,32'h0,    0,0,0,1, 3'd2,0);
    tbl[19] = mk(1,0,0,0,1,32'hE, 0,32'h0,    0,0,1,0, 3'd1,0);
    tbl[20] = mk(1,0,0,0,0,32'h0, 0,32'h0,    0,0,0,0, 3'd0,0);
    tbl[21] = mk(1,0,0,0,1,32'h5, 0,32'h0,    0,0,0,0, 3'd0,0);
    tbl[22] = mk(1,0,0,0,0,32'h0, 0,32'h0,    0,0,0,0, 3'd0,1);
    tbl[23] = mk(1,0,0,0,0,32'h0, 0,32'h0,    0,0,0,0, 3'd0,1);

    resetn = 1'b0; m0_req = 1'b1; m1_req = 1'b1; s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
    set_fixed_masters();
    repeat (2) @(posedge clk);

    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      resetn = tbl[i].rstn; m0_req = tbl[i].r0; m1_req = tbl[i].r1;
      s_addr_ok = tbl[i].aok; s_data_ok = tbl[i].dok; s_rdata = tbl[i].rdata;
      #2;
      chk($sformatf("v%0d_s_req", i), 32'(s_req), 32'(tbl[i].e_sreq));
      chk($sformatf("v%0d_s_addr", i), s_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_m0_addr_ok", i), 32'(m0_addr_ok), 32'(tbl[i].e_a0));
      chk($sformatf("v%0d_m1_addr_ok", i), 32'(m1_addr_ok), 32'(tbl[i].e_a1));
      chk($sformatf("v%0d_m0_data_ok", i), 32'(m0_data_ok), 32'(tbl[i].e_d0));
      chk($sformatf("v%0d_m1_data_ok", i), 32'(m1_data_ok), 32'(tbl[i].e_d1));
      chk($sformatf("v%0d_outstanding", i), 32'(outstanding), 32'(tbl[i].e_out));
      chk($sformatf("v%0d_err_spurious", i), 32'(err_spurious), 32'(tbl[i].e_err));
      if (tbl[i].e_d0) chk($sformatf("v%0d_m0_rdata", i), m0_rdata, tbl[i].rdata);
      if (tbl[i].e_d1) chk($sformatf("v%0d_m1_rdata", i), m1_rdata, tbl[i].rdata);
    end

    // Both masters requesting back-to-back: fixed priority keeps m1, round-robin alternates.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      resetn = 1'b1; m0_req = 1'b1; m1_req = 1'b1; s_addr_ok = 1'b1; s_data_ok = 1'b0;
      #2;
      chk($sformatf("pri%0d_s_addr", i), s_addr, exp_pri[i]);
      chk($sformatf("pri%0d_s_req", i), 32'(s_req), 32'h1);
    end

    do_reset();
    for (int i = 0; i < 600; i++) begin
      rand_cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Shares one downstream sram-like port between two requesters: the instruction fetch port (m0, IF stage) and the data port (m1, EXE/MEM stages).
- Sits between the pipeline and the AXI bridge.
- Tracks outstanding transactions in an in-order source FIFO, so each downstream data_ok/rdata goes back to the requester that issued it.
- Fixed data-over-inst priority by default, with grant lock while a request is pending.

Parameters:
- DEPTH, 4, max outstanding accepted-but-unanswered transactions (power of 2, ≥2)
- PTR_W, 2, log2(DEPTH)

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- m0_req  in  1  inst request
- m0_wr  in  1  inst write
- m0_size  in  2  inst size
- m0_wstrb  in  4  inst byte strobe
- m0_addr  in  32  inst address
- m0_wdata  in  32  inst write data
- m0_addr_ok  out  1  inst request accepted
- m0_data_ok  out  1  inst response
- m0_rdata  out  32  inst read data
- m1_req, m1_wr, m1_size, m1_wstrb, m1_addr, m1_wdata, m1_addr_ok, m1_data_ok, m1_rdata: same directions and widths as m0_*, data requester
- s_req  out  1  downstream request
- s_wr  out  1  downstream write
- s_size  out  2  downstream size
- s_wstrb  out  4  downstream byte strobe
- s_addr  out  32  downstream address
- s_wdata  out  32  downstream write data
- s_addr_ok  in  1  downstream accept
- s_data_ok  in  1  downstream response, in order
- s_rdata  in  32  downstream read data
- outstanding  out  PTR_W+1  count of in-flight transactions
- err_spurious  out  1  sticky: s_data_ok seen with FIFO empty

Behaviour:
- Reset (resetn=0 at posedge):
  - FIFO pointers, count, grant lock and err_spurious cleared.
  - All registered state cleared.
  - s_req=0, m*_addr_ok=0, m*_data_ok=0; outstanding=0.
- Grant state machine, states IDLE / LOCK0 / LOCK1:
  - IDLE: if m1_req, grant m1; else if m0_req, grant m0. Grant is combinational in the same cycle.
  - If the granted request is not accepted this cycle, go to LOCKn. LOCKn holds grant to master n until its handshake completes, so s_* stays stable.
  - On handshake, return to IDLE.
  - A lock is dropped (back to IDLE) if the locked master deasserts req.
- Muxing:
  - s_req = granted m_req & ~full.
  - s_wr, s_size, s_wstrb, s_addr and s_wdata come from the granted master; they are 0 when nothing is granted.
- Handshake:
  - mN_addr_ok = grant==N & s_addr_ok & ~full. It is combinational, and only the granted master sees it.
  - On handshake, push N into the source FIFO.
- Response routing:
  - s_data_ok pops the FIFO head. The popped source gets mN_data_ok=1 in the same cycle.
  - mN_rdata = s_rdata for both masters. Only the data_ok qualifier differs.
- Full (count==DEPTH): s_req forced 0, no addr_ok. A pop in the same cycle does NOT unblock the push; the push waits one cycle.
- Empty with s_data_ok=1: no data_ok to either master, err_spurious set (sticky until reset), count stays 0.
- Simultaneous push and pop: count unchanged, both pointers advance and wrap modulo DEPTH.
- Write responses: data_ok is routed like reads; rdata is don't-care.
- No internal flush. Cancelled transactions are still answered; the requester discards them.
- Latency: 0 cycles added on request and on response path.

Optional Feature:
- Macro SRAM_ARB_RR_EN.
- Defined:
  - IDLE arbitration is round-robin. A 1-bit last_grant register (reset 0 = m0) gives priority to the master not granted last; it updates on each handshake.
  - Locks are unchanged.
- Undefined: fixed m1 priority; no last_grant register.

Test Plan:
- Reset: resetn=0 for 2 cycles with m0_req=m1_req=1 -> s_req=0, outstanding=0, err_spurious=0.
- Contention, fixed priority: m0_req=m1_req=1, m1_addr=0x1000, s_addr_ok=1 -> s_addr=0x1000, m1_addr_ok=1, m0_addr_ok=0. Next cycle m0 is granted, s_addr=m0_addr.
- Grant lock: m0_req alone with s_addr_ok=0 for 3 cycles, m1_req rises in cycle 2 -> s_addr stays m0_addr; after s_addr_ok, m0_addr_ok=1, then m1 is granted.
- Ordering and full:
  - Issue m0, m1, m0, m1 with s_data_ok held 0 -> outstanding=4.
  - Fifth request gets s_req=0.
  - Then 4 s_data_ok pulses with rdata 0xA,0xB,0xC,0xD -> m0_data_ok,m1_data_ok,m0_data_ok,m1_data_ok in order with matching rdata.
- Push+pop: outstanding=2, a handshake and s_data_ok in the same cycle -> outstanding stays 2, the correct source pops; wrap is exercised across 10 transactions.
- Spurious: s_data_ok=1 with outstanding=0 -> no mN_data_ok, err_spurious=1 and held.
- With SRAM_ARB_RR_EN: both requesting continuously with s_addr_ok=1 -> grants alternate m1,m0,m1,m0.
